mem_port_arbiter: RTL and testbench
===================================

Name:
mem_port_arbiter

Overview:
Shares the single AXI memory port between the I-cache refill, D-cache refill and D-cache writeback paths. Independent read and write FSMs sequence address, burst-data and response phases, with round-robin read arbitration and a read-after-writeback line hazard interlock. It sits between the cache main FSMs (r_req/r_rdy, w_req/w_rdy, wrt_AXI_finish style handshakes) and the top-level AXI wrapper.

Parameters:
LINE_WORDS, 16, 32-bit words per cache line = burst beats; power of two, at least 2
ADDR_W, 32, address width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
ic_r_req  in  1  I-cache refill request
ic_r_addr  in  ADDR_W  I-cache line address
ic_r_rdy  out  1  one-cycle pulse: I-cache read accepted (AR handshake done)
ic_ret_valid  out  1  ret_data holds an I-cache refill beat
dc_r_req  in  1  D-cache refill request
dc_r_addr  in  ADDR_W  D-cache line address
dc_r_rdy  out  1  one-cycle pulse: D-cache read accepted
dc_ret_valid  out  1  ret_data holds a D-cache refill beat
ret_data  out  32  refill beat, shared by both caches
dc_w_req  in  1  D-cache writeback request
dc_w_addr  in  ADDR_W  writeback line address
dc_w_rdy  out  1  one-cycle pulse: writeback accepted (AW handshake done)
dc_w_data  in  32  current writeback word from the cache write buffer
dc_w_data_next  out  1  current word consumed; buffer advances
dc_wrt_finish  out  1  one-cycle pulse: B response received
arvalid  out  1  AXI read address valid
araddr  out  ADDR_W  AXI read address
arready  in  1  AXI read address ready
rvalid  in  1  AXI read data valid
rdata  in  32  AXI read data
rlast  in  1  AXI last read beat
awvalid  out  1  AXI write address valid
awaddr  out  ADDR_W  AXI write address
awready  in  1  AXI write address ready
wvalid  out  1  AXI write data valid
wdata  out  32  AXI write data
wlast  out  1  AXI last write beat
wready  in  1  AXI write data ready
bvalid  in  1  AXI write response valid

Behaviour:
- The wrapper ties rready=1 and bready=1, arlen=awlen=LINE_WORDS-1, INCR burst, 4-byte size. No IDs; one read and one write outstanding at most.
- Reset: all outputs 0. Read FSM to R_IDLE, write FSM to W_IDLE. Round-robin pointer favours the I-cache. Beat counter is 0.
- Reset mid-burst: both FSMs return to idle and any in-flight beats are dropped. The wrapper resets the AXI slave at the same time.
- Read FSM, R_IDLE: arbitrates among eligible requests. If both are eligible, the one not granted last wins. The owner and its address are latched, then the FSM goes to R_ADDR. A request is sampled only in R_IDLE; once latched, later deassertion is ignored.
- Read FSM, R_ADDR: arvalid=1 and araddr=latched address. On arready, the owner's x_r_rdy pulses and the FSM goes to R_DATA.
- Read FSM, R_DATA: ret_data=rdata and owner_ret_valid=rvalid, both combinational. On rvalid&&rlast the FSM goes to R_IDLE, the pointer flips and nothing is granted that cycle.
- Write FSM, W_IDLE: on dc_w_req the address is latched and the FSM goes to W_ADDR.
- Write FSM, W_ADDR: awvalid=1. On awready, dc_w_rdy pulses and the FSM goes to W_DATA.
- Write FSM, W_DATA: wvalid=1, wdata=dc_w_data, dc_w_data_next=wready. The counter increments per accepted beat. wlast=(count==LINE_WORDS-1). After the last accepted beat the counter clears and the FSM goes to W_RESP.
- Write FSM, W_RESP: on bvalid, dc_wrt_finish pulses and the FSM goes to W_IDLE.
- The read and write FSMs run concurrently.
- Hazard: dc_r_req is ineligible while the write FSM is not in W_IDLE and the line addresses match (addr[ADDR_W-1:log2(LINE_WORDS*4)]). I-cache reads are never blocked.

Decomposition:
Shared package holds the read and write FSM state encodings and LINE_OFF_W=log2(LINE_WORDS*4). One natural sub-module: rr_arb2, a 2-way round-robin picker with an eligibility mask and an update strobe.

Test Plan:
- ic_r_req and dc_r_req rise together after reset: I-cache granted first (araddr=ic addr, ic_r_rdy pulse), 16 beats reach ic_ret_valid only, then D-cache granted next.
- dc_w_req addr 0x1000 with 16 beats where wready stalls every other cycle: exactly 16 dc_w_data_next pulses, wlast only on the 16th, dc_wrt_finish one cycle after bvalid.
- Writeback 0x2000 in flight while dc_r_req 0x2004 is raised: no AR until dc_wrt_finish. dc_r_req 0x3000 instead is granted immediately.
- Continuous ic_r_req and dc_r_req for 4 bursts: grants alternate I, D, I, D, with no overlapping ret_valid.
- rstn low during beat 5 of a read: all outputs 0 the next cycle, FSMs idle, and a fresh request works normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: read/write FSM encodings, read owner
// identity and the line-offset width helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } w_state_e;

  // Requester index on the read side; also the bit position in the arbiter masks.
  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } r_owner_e;

  localparam int DEF_LINE_WORDS = 16;

  // Byte-offset bits inside one cache line of 32-bit words.
  function automatic int line_off_w(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  localparam int LINE_OFF_W = line_off_w(DEF_LINE_WORDS);

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: requests are masked by eligibility, and on the
// update strobe the priority moves to the requester that was not served last.
module mem_port_arbiter_rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_i,
  input  logic [1:0] elig_i,
  input  logic       update_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_o
);

  logic       favour_q;
  logic [1:0] cand;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can leave a latch behind.
  always_comb begin
    cand        = req_i & elig_i;
    gnt_valid_o = |cand;
    gnt_o       = OWN_IC;
    if (cand == 2'b11) begin
      gnt_o = favour_q;
    end else if (cand[OWN_DC]) begin
      gnt_o = OWN_DC;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      favour_q <= OWN_IC;
    end else if (update_i) begin
      favour_q <= ~last_i;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one AXI port between I-cache refill, D-cache refill and D-cache
// writeback; read and write FSMs run independently with a line hazard interlock.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ic_r_req,
  input  logic [ADDR_W-1:0] ic_r_addr,
  output logic              ic_r_rdy,
  output logic              ic_ret_valid,
  input  logic              dc_r_req,
  input  logic [ADDR_W-1:0] dc_r_addr,
  output logic              dc_r_rdy,
  output logic              dc_ret_valid,
  output logic [31:0]       ret_data,
  input  logic              dc_w_req,
  input  logic [ADDR_W-1:0] dc_w_addr,
  output logic              dc_w_rdy,
  input  logic [31:0]       dc_w_data,
  output logic              dc_w_data_next,
  output logic              dc_wrt_finish,
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [31:0]       rdata,
  input  logic              rlast,
  output logic              awvalid,
  output logic [ADDR_W-1:0] awaddr,
  input  logic              awready,
  output logic              wvalid,
  output logic [31:0]       wdata,
  output logic              wlast,
  input  logic              wready,
  input  logic              bvalid
);

  localparam int              OFF_W     = line_off_w(LINE_WORDS);
  localparam int              CNT_W     = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  r_state_e          r_state_q;
  r_owner_e          r_owner_q;
  logic [ADDR_W-1:0] r_addr_q;
  logic              arvalid_q;
  logic              ic_r_rdy_q;
  logic              dc_r_rdy_q;

  w_state_e          w_state_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [CNT_W-1:0]  w_cnt_q;
  logic [CNT_W-1:0]  w_cnt_d;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              dc_w_rdy_q;
  logic              dc_wrt_finish_q;

  logic              dc_hazard;
  logic              gnt_valid;
  logic              gnt;
  logic              r_done;
  logic              w_beat;
  logic              w_last_beat;

  // A D-cache refill must not overtake a writeback of the same line.
  assign dc_hazard = (w_state_q != W_IDLE) &&
                     (dc_r_addr[ADDR_W-1:OFF_W] == w_addr_q[ADDR_W-1:OFF_W]);

  assign r_done = (r_state_q == R_DATA) && rvalid && rlast;

  mem_port_arbiter_rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rstn        (rstn),
    .req_i       ({dc_r_req, ic_r_req}),
    .elig_i      ({~dc_hazard, 1'b1}),
    .update_i    (r_done),
    .last_i      (r_owner_q),
    .gnt_valid_o (gnt_valid),
    .gnt_o       (gnt)
  );

  // ---------------------------------------------------------------- read FSM
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state_q  <= R_IDLE;
      r_owner_q  <= OWN_IC;
      r_addr_q   <= '0;
      arvalid_q  <= 1'b0;
      ic_r_rdy_q <= 1'b0;
      dc_r_rdy_q <= 1'b0;
    end else begin
      ic_r_rdy_q <= 1'b0;
      dc_r_rdy_q <= 1'b0;
      case (r_state_q)
        R_IDLE: begin
          if (gnt_valid) begin
            r_owner_q <= r_owner_e'(gnt);
            r_addr_q  <= (gnt == OWN_DC) ? dc_r_addr : ic_r_addr;
            arvalid_q <= 1'b1;
            r_state_q <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (arready) begin
            arvalid_q  <= 1'b0;
            ic_r_rdy_q <= (r_owner_q == OWN_IC);
            dc_r_rdy_q <= (r_owner_q == OWN_DC);
            r_state_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_done) begin
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- write FSM
  assign w_beat      = wvalid_q && wready;
  assign w_last_beat = w_beat && (w_cnt_q == LAST_BEAT);

  always_comb begin
    w_cnt_d = w_cnt_q;
    if (w_last_beat) begin
      w_cnt_d = '0;
    end else if (w_beat) begin
      w_cnt_d = w_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state_q       <= W_IDLE;
      w_addr_q        <= '0;
      w_cnt_q         <= '0;
      awvalid_q       <= 1'b0;
      wvalid_q        <= 1'b0;
      dc_w_rdy_q      <= 1'b0;
      dc_wrt_finish_q <= 1'b0;
    end else begin
      dc_w_rdy_q      <= 1'b0;
      dc_wrt_finish_q <= 1'b0;
      w_cnt_q         <= w_cnt_d;
      case (w_state_q)
        W_IDLE: begin
          if (dc_w_req) begin
            w_addr_q  <= dc_w_addr;
            awvalid_q <= 1'b1;
            w_state_q <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (awready) begin
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b1;
            dc_w_rdy_q <= 1'b1;
            w_state_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_last_beat) begin
            wvalid_q  <= 1'b0;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            dc_wrt_finish_q <= 1'b1;
            w_state_q       <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- outputs
  assign arvalid       = arvalid_q;
  assign araddr        = r_addr_q;
  assign ic_r_rdy      = ic_r_rdy_q;
  assign dc_r_rdy      = dc_r_rdy_q;

  // Refill beats pass straight through; gating by state keeps them 0 when idle.
  assign ic_ret_valid  = (r_state_q == R_DATA) && (r_owner_q == OWN_IC) && rvalid;
  assign dc_ret_valid  = (r_state_q == R_DATA) && (r_owner_q == OWN_DC) && rvalid;
  assign ret_data      = (r_state_q == R_DATA) ? rdata : 32'd0;

  assign awvalid        = awvalid_q;
  assign awaddr         = w_addr_q;
  assign dc_w_rdy       = dc_w_rdy_q;
  assign wvalid         = wvalid_q;
  assign wdata          = wvalid_q ? dc_w_data : 32'd0;
  assign wlast          = wvalid_q && (w_cnt_q == LAST_BEAT);
  assign dc_w_data_next = w_beat;
  assign dc_wrt_finish  = dc_wrt_finish_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-plus-random bench for mem_port_arbiter; the AXI slave and cache
// sides are driven cycle by cycle and checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int LINE_WORDS = 16;
  localparam int ADDR_W     = 32;

  logic              clk = 1'b0;
  logic              rstn;
  logic              ic_r_req, dc_r_req, dc_w_req;
  logic [ADDR_W-1:0] ic_r_addr, dc_r_addr, dc_w_addr;
  logic              ic_r_rdy, ic_ret_valid, dc_r_rdy, dc_ret_valid;
  logic [31:0]       ret_data;
  logic              dc_w_rdy, dc_w_data_next, dc_wrt_finish;
  logic [31:0]       dc_w_data;
  logic              arvalid, arready, rvalid, rlast;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [31:0]       rdata, wdata;
  logic              awvalid, awready, wvalid, wlast, wready, bvalid;

  logic [138:0]      all_outs;

  int n_cmp = 0;
  int n_mis = 0;
  int last_grant = -1;  // -1: nobody served yet, so the I-cache is favoured

  always #5 clk = ~clk;

  mem_port_arbiter #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn),
    .ic_r_req(ic_r_req), .ic_r_addr(ic_r_addr), .ic_r_rdy(ic_r_rdy), .ic_ret_valid(ic_ret_valid),
    .dc_r_req(dc_r_req), .dc_r_addr(dc_r_addr), .dc_r_rdy(dc_r_rdy), .dc_ret_valid(dc_ret_valid),
    .ret_data(ret_data),
    .dc_w_req(dc_w_req), .dc_w_addr(dc_w_addr), .dc_w_rdy(dc_w_rdy), .dc_w_data(dc_w_data),
    .dc_w_data_next(dc_w_data_next), .dc_wrt_finish(dc_wrt_finish),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rlast(rlast),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wlast(wlast), .wready(wready),
    .bvalid(bvalid)
  );

  assign all_outs = {ic_r_rdy, ic_ret_valid, dc_r_rdy, dc_ret_valid, ret_data,
                     dc_w_rdy, dc_w_data_next, dc_wrt_finish,
                     arvalid, araddr, awvalid, awaddr, wvalid, wdata, wlast};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: with both eligible, the one not served last wins.
  function automatic int pick(input bit ic, input bit dc_ok);
    if (ic && dc_ok) return (last_grant == 0) ? 1 : 0;
    return dc_ok ? 1 : 0;
  endfunction

  function automatic logic [31:0] rand_line();
    return $urandom & 32'hffff_ffc0;
  endfunction

  // One refill burst: AR phase, rdy pulse, LINE_WORDS beats with random gaps.
  // abort_beat >= 0 pulls rstn low while that beat is on the bus.
  task automatic read_burst(input int owner, input logic [31:0] addr, input bit drop,
                            input int abort_beat);
    int beats;
    settle();
    for (int i = 0; i < 40; i++) begin
      if (arvalid) break;
      tick(); settle();
    end
    check("ar_valid", arvalid, 1);
    if (!arvalid) return;
    check("ar_addr", araddr, addr);
    repeat ($urandom_range(0, 2)) begin
      tick(); settle();
      check("ar_hold", {arvalid, araddr}, {1'b1, addr});
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    settle();
    check("r_rdy", {ic_r_rdy, dc_r_rdy, arvalid}, {owner == 0, owner == 1, 1'b0});
    last_grant = owner;
    if (drop) begin
      if (owner == 0) ic_r_req = 1'b0;
      else            dc_r_req = 1'b0;
    end
    tick();
    beats = 0;
    for (int b = 0; b < LINE_WORDS; b++) begin
      repeat ($urandom_range(0, 2)) begin
        rvalid = 1'b0;
        settle();
        check("r_gap", {ic_ret_valid, dc_ret_valid, ic_r_rdy, dc_r_rdy}, 0);
        tick();
      end
      rvalid = 1'b1;
      rdata  = $urandom;
      rlast  = (b == LINE_WORDS - 1);
      if (b == abort_beat) begin
        rstn     = 1'b0;
        ic_r_req = 1'b0;
        dc_r_req = 1'b0;
        tick(); settle();
        check("rst_mid_burst", all_outs, 0);
        rvalid = 1'b0;
        tick();
        rstn = 1'b1;
        last_grant = -1;
        return;
      end
      settle();
      check("r_beat", {ic_ret_valid, dc_ret_valid, ret_data, arvalid},
            {owner == 0, owner == 1, rdata, 1'b0});
      beats += (owner == 0) ? int'(ic_ret_valid) : int'(dc_ret_valid);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    check("r_beats", beats, LINE_WORDS);
  endtask

  task automatic w_addr_phase(input logic [31:0] addr);
    dc_w_req  = 1'b1;
    dc_w_addr = addr;
    settle();
    check("aw_idle", awvalid, 0);
    tick(); settle();
    check("aw_valid", {awvalid, awaddr}, {1'b1, addr});
    repeat ($urandom_range(0, 2)) begin
      tick(); settle();
      check("aw_hold", {awvalid, awaddr, dc_w_rdy}, {1'b1, addr, 1'b0});
    end
    awready = 1'b1;
    tick();
    awready  = 1'b0;
    dc_w_req = 1'b0;
    settle();
    check("w_rdy", {dc_w_rdy, awvalid, wvalid}, 3'b101);
  endtask

  // alt=1: wready low on even cycles, high on odd; alt=0: random wready.
  task automatic w_data_phase(input bit alt, input bit no_ar);
    int acc;
    int nexts;
    acc   = 0;
    nexts = 0;
    for (int c = 0; c < 200 && acc < LINE_WORDS; c++) begin
      wready    = alt ? c[0] : 1'($urandom_range(0, 1));
      dc_w_data = $urandom;
      settle();
      check("w_beat", {wvalid, wdata, dc_w_data_next, wlast},
            {1'b1, dc_w_data, wready, acc == LINE_WORDS - 1});
      if (no_ar) check("hazard_no_ar", arvalid, 0);
      nexts += int'(dc_w_data_next);
      if (wready) acc++;
      tick();
    end
    wready = 1'b0;
    settle();
    check("w_nexts", nexts, LINE_WORDS);
    check("w_done", {wvalid, wlast, dc_w_data_next}, 0);
  endtask

  // Ends in the cycle where dc_wrt_finish must be high.
  task automatic w_resp_phase(input bit no_ar);
    repeat ($urandom_range(0, 3)) begin
      settle();
      check("b_wait", dc_wrt_finish, 0);
      if (no_ar) check("hazard_no_ar", arvalid, 0);
      tick();
    end
    bvalid = 1'b1;
    settle();
    check("b_pre", dc_wrt_finish, 0);
    if (no_ar) check("hazard_no_ar", arvalid, 0);
    tick();
    bvalid = 1'b0;
    settle();
    check("wrt_finish", {dc_wrt_finish, awvalid, wvalid}, 3'b100);
    if (no_ar) check("hazard_no_ar", arvalid, 0);
  endtask

  initial begin
    logic [31:0] a_ic, a_dc;
    int own;

    // Reset with busy-looking AXI inputs: every output must stay 0.
    rstn = 1'b0;
    ic_r_req = 1'b0; dc_r_req = 1'b0; dc_w_req = 1'b0;
    ic_r_addr = '0; dc_r_addr = '0; dc_w_addr = '0; dc_w_data = $urandom;
    arready = 1'b0; rvalid = 1'b1; rdata = $urandom; rlast = 1'b1;
    awready = 1'b0; wready = 1'b1; bvalid = 1'b1;
    repeat (3) tick();
    settle();
    check("reset_outs", all_outs, 0);
    rvalid = 1'b0; rlast = 1'b0; wready = 1'b0; bvalid = 1'b0;
    rstn = 1'b1;
    tick(); settle();
    check("idle_outs", all_outs, 0);

    // Simultaneous refill requests: I-cache first, then D-cache.
    a_ic = rand_line();
    a_dc = rand_line();
    ic_r_addr = a_ic; dc_r_addr = a_dc;
    ic_r_req = 1'b1; dc_r_req = 1'b1;
    own = pick(1, 1);
    read_burst(own, own ? a_dc : a_ic, 1, -1);
    own = pick(ic_r_req, dc_r_req);
    read_burst(own, own ? a_dc : a_ic, 1, -1);

    // Writeback to 0x1000 with wready low every other cycle.
    w_addr_phase(32'h0000_1000);
    w_data_phase(1, 0);
    w_resp_phase(0);
    tick(); settle();
    check("finish_one_cycle", dc_wrt_finish, 0);

    // Same-line refill waits for the writeback to finish.
    w_addr_phase(32'h0000_2000);
    dc_r_req = 1'b1; dc_r_addr = 32'h0000_2004;
    w_data_phase(0, 1);
    w_resp_phase(1);
    tick(); settle();
    check("hazard_release", {arvalid, araddr, dc_wrt_finish}, {1'b1, 32'h0000_2004, 1'b0});
    read_burst(pick(ic_r_req, 1), 32'h0000_2004, 1, -1);

    // Different-line refill is granted while the writeback is stalled.
    w_addr_phase(32'h0000_2000);
    dc_r_req = 1'b1; dc_r_addr = 32'h0000_3000;
    tick(); settle();
    check("no_hazard_grant", {arvalid, araddr, wvalid}, {1'b1, 32'h0000_3000, 1'b1});
    read_burst(pick(ic_r_req, 1), 32'h0000_3000, 1, -1);
    w_data_phase(0, 0);
    w_resp_phase(0);
    tick();

    // Continuous requests from both sides: grants must alternate.
    ic_r_req = 1'b1; dc_r_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_ic = rand_line(); a_dc = rand_line();
      ic_r_addr = a_ic; dc_r_addr = a_dc;
      own = pick(1, 1);
      check("rr_alternate", own, k % 2);
      read_burst(own, own ? a_dc : a_ic, 0, -1);
    end
    ic_r_req = 1'b0; dc_r_req = 1'b0;
    repeat (2) tick();
    settle();
    check("idle_after_rr", {arvalid, ic_ret_valid, dc_ret_valid}, 0);

    // Reset on the fifth beat of a refill, then normal operation resumes.
    a_ic = rand_line();
    ic_r_addr = a_ic; ic_r_req = 1'b1;
    read_burst(pick(1, 0), a_ic, 1, 4);
    settle();
    check("post_reset_idle", all_outs, 0);
    a_ic = rand_line(); a_dc = rand_line();
    ic_r_addr = a_ic; dc_r_addr = a_dc;
    ic_r_req = 1'b1; dc_r_req = 1'b1;
    own = pick(1, 1);
    read_burst(own, own ? a_dc : a_ic, 1, -1);
    own = pick(ic_r_req, dc_r_req);
    read_burst(own, own ? a_dc : a_ic, 1, -1);
    tick(); settle();
    check("final_idle", {arvalid, awvalid, wvalid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
